count_monitor: RTL and testbench
================================

Name: count_monitor

Overview:
- Downstream consumer of the 5-bit free-running `counter` output.
- Samples `count` every clock and checks that each new value is the previous value plus one, modulo 2^WIDTH.
- Reports lock status, counts legal wrap-arounds and flags/counts sequence errors.
- Used in tool_check benches and silicon debug as a self-checking sink for any counter stage.

Parameters:
- WIDTH, 5, width of the monitored count bus (must equal the counter width).
- WRAP_CNT_W, 16, width of the wrap-around statistics counter.
- ERR_CNT_W, 8, width of the error statistics counter.
- LOCK_CYCLES, 2, consecutive correct increments required to enter LOCKED (range 1..15).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- count  input  WIDTH  value from the upstream counter, sampled on every clk rising edge.
- clr  input  1  synchronous clear of statistics (wrap_cnt, err_cnt, err_sticky).
- locked  output  1  high while the FSM is in LOCKED.
- wrap  output  1  one-cycle pulse on a legal max-to-0 transition.
- wrap_cnt  output  WRAP_CNT_W  saturating count of wrap pulses.
- err  output  1  one-cycle pulse on a sequence mismatch while LOCKED.
- err_sticky  output  1  set by err; cleared only by rst or clr.
- err_cnt  output  ERR_CNT_W  saturating count of err pulses.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports `clk`, `rst`).
- Reset values:
  - Outputs: all outputs 0.
  - Internal: prev=0, good_run=0, state=SEED.
- Reset asserted mid-operation returns to these values immediately, without waiting for a clock edge.
- Definition: `inc_ok` = (count == prev + 1 mod 2^WIDTH), computed WIDTH bits wide so that max+1 wraps to 0. `prev` loads `count` on every edge while rst is low, in all states.
- FSM, evaluated on each rising edge with rst low:
  - SEED: capture prev, go to LOCKING with good_run=0. No output pulse.
  - LOCKING, inc_ok true:
    - good_run increments.
    - If the incremented good_run equals LOCK_CYCLES, go to LOCKED and clear good_run.
    - A legal max-to-0 increment here also raises wrap.
  - LOCKING, inc_ok false: good_run=0, stay in LOCKING. No err is raised (the monitor is not yet locked).
  - LOCKED, inc_ok true: stay in LOCKED. If prev was all-ones (so count=0), raise wrap.
  - LOCKED, inc_ok false:
    - Raise err and set err_sticky.
    - Go to LOCKING with good_run=0. The mismatching value becomes the new prev, which re-seeds the check.
- Latency:
  - All outputs are registered.
  - wrap and err are high for exactly the one cycle following the sampling edge that detected the event.
  - locked rises in the cycle after the edge that completes the LOCK_CYCLES-th good increment.
  - locked falls in the cycle after the edge that detects the error.
- Statistics counters:
  - wrap_cnt and err_cnt increment by 1 per pulse and saturate at all-ones (no roll-over).
- clr:
  - clr alone: wrap_cnt, err_cnt and err_sticky load 0. The FSM, prev and locked are unaffected.
  - clr on the same edge as an event: the event wins against the clear, so the counter loads 1 (and err_sticky loads 1 for err).
- A held count (same value twice) is a mismatch.
- A count that stays constant in LOCKING never locks.
- A single edge can never produce both wrap and err.

Test Plan:
- Reset release with the counter free-running 0,1,2,… and LOCK_CYCLES=2 → locked=0 after the first two sampling edges, locked=1 after the edge sampling 2. err stays 0 throughout.
- Run 70 cycles locked → wrap pulses exactly twice (on the 31→0 transitions), wrap_cnt=2, err_cnt=0, err_sticky=0.
- While locked, force count from 5 to 9 for one edge, then release to 10,11,… → err pulses once, err_cnt=1, err_sticky=1, locked drops. locked returns after the edges sampling 10 and 11. No second err.
- Hold count constant at 7 for 5 edges → one err on entry, then locked stays 0 with no further err. Resume incrementing → relock after 2 increments.
- Preload err_cnt to 255 via repeated injected errors → err_cnt stays 255 on further errors. Assert clr alone → err_cnt=0, err_sticky=0. Assert clr on the same edge as a wrap → wrap_cnt=1.
- Assert rst asynchronously mid-cycle while locked with wrap_cnt=3 → all outputs 0 immediately, without a clock edge. After release, the FSM re-seeds and relocks per the first scenario.

Source files
------------

// File: rtl/count_monitor_if.sv
// Bus between a counter stage under observation and the count_monitor sink.
// The master side drives count/clr; the monitor (slave side) reports status and statistics.
interface count_monitor_if #(
    parameter int WIDTH      = 5,
    parameter int WRAP_CNT_W = 16,
    parameter int ERR_CNT_W  = 8
);
    logic [WIDTH-1:0]      count;
    logic                  clr;
    logic                  locked;
    logic                  wrap;
    logic [WRAP_CNT_W-1:0] wrap_cnt;
    logic                  err;
    logic                  err_sticky;
    logic [ERR_CNT_W-1:0]  err_cnt;

    modport master (
        output count, clr,
        input  locked, wrap, wrap_cnt, err, err_sticky, err_cnt
    );

    modport slave (
        input  count, clr,
        output locked, wrap, wrap_cnt, err, err_sticky, err_cnt
    );
endinterface

// File: rtl/count_monitor.sv
// Self-checking sink for a free-running counter: verifies each sample is the previous
// sample plus one, reports lock, and keeps saturating wrap/error statistics.
module count_monitor #(
    parameter int WIDTH       = 5,
    parameter int WRAP_CNT_W  = 16,
    parameter int ERR_CNT_W   = 8,
    parameter int LOCK_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    count_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        SEED    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      prev_q, prev_d;
    logic [3:0]            good_run_q, good_run_d;
    logic                  locked_q, locked_d;
    logic                  wrap_q, wrap_d;
    logic                  err_q, err_d;
    logic                  err_sticky_q, err_sticky_d;
    logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]      prev_plus_one;
    logic                  inc_ok;
    logic                  is_zero;
    logic [3:0]            good_run_inc;

    assign prev_plus_one = prev_q + WIDTH'(1);
    assign inc_ok        = (bus.count == prev_plus_one);
    assign is_zero       = (bus.count == '0);
    assign good_run_inc  = good_run_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        good_run_d = good_run_q;
        prev_d     = bus.count;
        wrap_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            SEED: begin
                state_d    = LOCKING;
                good_run_d = 4'd0;
            end
            LOCKING: begin
                if (inc_ok) begin
                    wrap_d = is_zero;
                    if (good_run_inc == 4'(LOCK_CYCLES)) begin
                        state_d    = LOCKED;
                        good_run_d = 4'd0;
                    end else begin
                        good_run_d = good_run_inc;
                    end
                end else begin
                    good_run_d = 4'd0;
                end
            end
            LOCKED: begin
                if (inc_ok) begin
                    wrap_d = is_zero;
                end else begin
                    err_d      = 1'b1;
                    state_d    = LOCKING;
                    good_run_d = 4'd0;
                end
            end
            default: begin
                state_d    = SEED;
                good_run_d = 4'd0;
            end
        endcase

        locked_d = (state_d == LOCKED);

        // An event on the same edge as clr wins: the counter restarts at one, not zero.
        wrap_cnt_d = wrap_cnt_q;
        if (wrap_d) begin
            if (bus.clr)
                wrap_cnt_d = WRAP_CNT_W'(1);
            else if (wrap_cnt_q != '1)
                wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
        end else if (bus.clr) begin
            wrap_cnt_d = '0;
        end

        err_cnt_d = err_cnt_q;
        if (err_d) begin
            if (bus.clr)
                err_cnt_d = ERR_CNT_W'(1);
            else if (err_cnt_q != '1)
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end else if (bus.clr) begin
            err_cnt_d = '0;
        end

        err_sticky_d = err_sticky_q;
        if (err_d)
            err_sticky_d = 1'b1;
        else if (bus.clr)
            err_sticky_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SEED;
            prev_q       <= '0;
            good_run_q   <= 4'd0;
            locked_q     <= 1'b0;
            wrap_q       <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            wrap_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_run_q   <= good_run_d;
            locked_q     <= locked_d;
            wrap_q       <= wrap_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            wrap_cnt_q   <= wrap_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.locked     = locked_q;
    assign bus.wrap       = wrap_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.wrap_cnt   = wrap_cnt_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor: directed vector table, hand-written corner
// sequences, and a randomized run checked against a sequence-rule reference model.
module tb_count_monitor;

    localparam int WIDTH      = 5;
    localparam int WRAP_CNT_W = 16;
    localparam int ERR_CNT_W  = 8;
    localparam int LOCK       = 2;
    localparam int MODV       = 1 << WIDTH;
    localparam int WRAP_MAX   = (1 << WRAP_CNT_W) - 1;
    localparam int ERR_MAX    = (1 << ERR_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    count_monitor_if #(.WIDTH(WIDTH), .WRAP_CNT_W(WRAP_CNT_W), .ERR_CNT_W(ERR_CNT_W)) bus ();

    count_monitor #(
        .WIDTH(WIDTH), .WRAP_CNT_W(WRAP_CNT_W), .ERR_CNT_W(ERR_CNT_W), .LOCK_CYCLES(LOCK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state: what a monitor obeying the sequence rules should report.
    bit m_have_prev;
    int m_prev;
    bit m_locked;
    int m_run;
    bit m_wrap;
    bit m_err;
    bit m_sticky;
    int m_wraps;
    int m_errs;

    typedef struct {
        int c;
        bit k;
        bit locked;
        bit wrap;
        bit err;
        bit sticky;
        int errcnt;
    } vec_t;

    vec_t tbl[10];
    int   wrap_seen;
    int   err_seen;

    task automatic modelReset();
        m_have_prev = 0; m_prev = 0; m_locked = 0; m_run = 0;
        m_wrap = 0; m_err = 0; m_sticky = 0; m_wraps = 0; m_errs = 0;
    endtask

    task automatic modelStep(input int c, input bit k);
        bit good;
        good   = m_have_prev && (c == (m_prev + 1) % MODV);
        m_wrap = 0;
        m_err  = 0;
        if (!m_have_prev) begin
            m_have_prev = 1;
            m_run       = 0;
        end else if (m_locked) begin
            if (good) m_wrap = (c == 0);
            else begin m_err = 1; m_locked = 0; m_run = 0; end
        end else if (good) begin
            m_wrap = (c == 0);
            m_run++;
            if (m_run == LOCK) begin m_locked = 1; m_run = 0; end
        end else begin
            m_run = 0;
        end
        m_prev = c;
        if (m_wrap) m_wraps = k ? 1 : (m_wraps < WRAP_MAX ? m_wraps + 1 : WRAP_MAX);
        else if (k) m_wraps = 0;
        if (m_err) m_errs = k ? 1 : (m_errs < ERR_MAX ? m_errs + 1 : ERR_MAX);
        else if (k) m_errs = 0;
        if (m_err) m_sticky = 1;
        else if (k) m_sticky = 0;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("locked",     int'(bus.locked),     int'(m_locked));
        checkOutput("wrap",       int'(bus.wrap),       int'(m_wrap));
        checkOutput("err",        int'(bus.err),        int'(m_err));
        checkOutput("err_sticky", int'(bus.err_sticky), int'(m_sticky));
        checkOutput("wrap_cnt",   int'(bus.wrap_cnt),   m_wraps);
        checkOutput("err_cnt",    int'(bus.err_cnt),    m_errs);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".locked"},     int'(bus.locked),     0);
        checkOutput({tag, ".wrap"},       int'(bus.wrap),       0);
        checkOutput({tag, ".err"},        int'(bus.err),        0);
        checkOutput({tag, ".err_sticky"}, int'(bus.err_sticky), 0);
        checkOutput({tag, ".wrap_cnt"},   int'(bus.wrap_cnt),   0);
        checkOutput({tag, ".err_cnt"},    int'(bus.err_cnt),    0);
    endtask

    // Drive one sample, let the DUT take it on the next rising edge, check 1ns later.
    task automatic applyStimulus(input int c, input bit k);
        bus.count = WIDTH'(c);
        bus.clr   = k;
        @(posedge clk);
        modelStep(c, k);
        #1;
        checkModel();
        if (bus.wrap) wrap_seen++;
        if (bus.err)  err_seen++;
        bus.clr = 1'b0;
    endtask

    task automatic step(input int c);
        applyStimulus(c, 1'b0);
    endtask

    task automatic nextInc();
        step((m_prev + 1) % MODV);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int r;
        bus.count = '0;
        bus.clr   = 1'b0;
        modelReset();
        #2;
        checkAllZero("por");
        @(negedge clk);
        rst = 1'b0;

        // Lock from reset, then a single-edge glitch 5->9 and recovery.
        tbl[0] = '{0,  0, 0, 0, 0, 0, 0};
        tbl[1] = '{1,  0, 0, 0, 0, 0, 0};
        tbl[2] = '{2,  0, 1, 0, 0, 0, 0};
        tbl[3] = '{3,  0, 1, 0, 0, 0, 0};
        tbl[4] = '{4,  0, 1, 0, 0, 0, 0};
        tbl[5] = '{5,  0, 1, 0, 0, 0, 0};
        tbl[6] = '{9,  0, 0, 0, 1, 1, 1};
        tbl[7] = '{10, 0, 0, 0, 0, 1, 1};
        tbl[8] = '{11, 0, 1, 0, 0, 1, 1};
        tbl[9] = '{12, 0, 1, 0, 0, 1, 1};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].c, tbl[i].k);
            checkOutput($sformatf("tbl%0d.locked", i), int'(bus.locked),     int'(tbl[i].locked));
            checkOutput($sformatf("tbl%0d.wrap", i),   int'(bus.wrap),       int'(tbl[i].wrap));
            checkOutput($sformatf("tbl%0d.err", i),    int'(bus.err),        int'(tbl[i].err));
            checkOutput($sformatf("tbl%0d.sticky", i), int'(bus.err_sticky), int'(tbl[i].sticky));
            checkOutput($sformatf("tbl%0d.errcnt", i), int'(bus.err_cnt),    tbl[i].errcnt);
        end

        // 73 free-running samples from reset: exactly two 31->0 wraps.
        doReset();
        wrap_seen = 0;
        err_seen  = 0;
        for (int i = 0; i <= 72; i++) step(i % MODV);
        checkOutput("run70.wrap_pulses", wrap_seen, 2);
        checkOutput("run70.wrap_cnt",    int'(bus.wrap_cnt), 2);
        checkOutput("run70.err_cnt",     int'(bus.err_cnt), 0);
        checkOutput("run70.sticky",      int'(bus.err_sticky), 0);
        checkOutput("run70.locked",      int'(bus.locked), 1);

        // Hold at 7: one err on entry, none after, relock after two increments.
        while (m_prev != 6) nextInc();
        step(7);
        err_seen = 0;
        for (int i = 0; i < 4; i++) step(7);
        checkOutput("hold.err_pulses", err_seen, 1);
        checkOutput("hold.locked",     int'(bus.locked), 0);
        step(8);
        checkOutput("hold.relock1", int'(bus.locked), 0);
        step(9);
        checkOutput("hold.relock2", int'(bus.locked), 1);
        checkOutput("hold.err_cnt", int'(bus.err_cnt), 1);

        // Drive err_cnt into saturation: each round locks, then repeats a value.
        for (int i = 0; i < 260; i++) begin
            nextInc();
            nextInc();
            step(m_prev);
        end
        checkOutput("sat.err_cnt", int'(bus.err_cnt), 255);
        nextInc(); nextInc(); step(m_prev);
        checkOutput("sat.err_pulse", int'(bus.err), 1);
        checkOutput("sat.err_hold",  int'(bus.err_cnt), 255);
        applyStimulus((m_prev + 1) % MODV, 1'b1);
        checkOutput("clr.err_cnt", int'(bus.err_cnt), 0);
        checkOutput("clr.sticky",  int'(bus.err_sticky), 0);

        // clr coinciding with a wrap: the wrap wins and the count restarts at 1.
        nextInc(); nextInc();
        while (m_prev != 31) nextInc();
        applyStimulus(0, 1'b1);
        checkOutput("clrwrap.wrap",     int'(bus.wrap), 1);
        checkOutput("clrwrap.wrap_cnt", int'(bus.wrap_cnt), 1);

        // Asynchronous reset mid-cycle while locked with wrap_cnt=3.
        doReset();
        for (int i = 0; i <= 100; i++) step(i % MODV);
        checkOutput("pre_arst.wrap_cnt", int'(bus.wrap_cnt), 3);
        checkOutput("pre_arst.locked",   int'(bus.locked), 1);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkAllZero("arst");
        @(negedge clk);
        rst = 1'b0;
        step(0);
        checkOutput("arst.seed",  int'(bus.locked), 0);
        step(1);
        checkOutput("arst.good1", int'(bus.locked), 0);
        step(2);
        checkOutput("arst.lock",  int'(bus.locked), 1);

        // Randomized mix of increments, holds, jumps and clears.
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6)       c = $urandom_range(0, MODV - 1);
            else if (r < 10) c = m_prev;
            else             c = (m_prev + 1) % MODV;
            applyStimulus(c, ($urandom_range(0, 99) < 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
